// File: rtl/countdown_timer.sv
// Settable HH:MM:SS countdown timer driven by the shared 1 Hz strobe.
// Borrows cascade seconds -> minutes -> hours; o_done pulses once on reaching zero.
module countdown_timer #(
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic       i_sysclk,
  input  logic       i_reset_n,
  input  logic       i_1hz_stb,
  input  logic       i_load,
  input  logic [4:0] i_load_hours,
  input  logic [5:0] i_load_minutes,
  input  logic [5:0] i_load_seconds,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_running,
  output logic       o_done
);
  localparam logic [5:0] SEC_TOP  = 6'(SEC_MAX - 1);
  localparam logic [5:0] MIN_TOP  = 6'(MIN_MAX - 1);
  localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state, next_state;
  logic       count_zero, count_one, tick, last_tick;
  logic       running_d, done_d;
  logic [4:0] dec_hours;
  logic [5:0] dec_minutes, dec_seconds;

  function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] top);
    return (v > top) ? top : v;
  endfunction

  function automatic logic [4:0] sat5(input logic [4:0] v, input logic [4:0] top);
    return (v > top) ? top : v;
  endfunction

  assign count_zero = (o_hours == '0) && (o_minutes == '0) && (o_seconds == '0);
  assign count_one  = (o_hours == '0) && (o_minutes == '0) && (o_seconds == 6'd1);
  // A strobe only counts if the timer was already running and no load/pause shares the edge
  assign tick       = (state == RUN) && i_1hz_stb && !i_load && !i_pause && !count_zero;
  assign last_tick  = tick && count_one;

  always_comb begin
    dec_hours   = o_hours;
    dec_minutes = o_minutes;
    dec_seconds = o_seconds - 6'd1;
    if (o_seconds == '0) begin
      dec_seconds = SEC_TOP;
      dec_minutes = o_minutes - 6'd1;
      if (o_minutes == '0) begin
        dec_minutes = MIN_TOP;
        dec_hours   = o_hours - 5'd1;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // Pause outranks start even when both arrive in a state where pause alone does nothing
  always_comb begin
    next_state = state;
    if (i_load) begin
      next_state = IDLE;
    end else if (i_pause) begin
      if (state == RUN) next_state = PAUSED;
    end else if (i_start && (state == IDLE || state == PAUSED) && !count_zero) begin
      next_state = RUN;
    end else if (last_tick) begin
      next_state = EXPIRED;
    end
  end

  always_comb begin
    running_d = (next_state == RUN);
    done_d    = last_tick;
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_running <= running_d;
      o_done    <= done_d;
    end
  end

  // Count fields clear on reset too, so a reset mid-count reads back 00:00:00
  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      o_hours   <= '0;
      o_minutes <= '0;
      o_seconds <= '0;
    end else if (i_load) begin
      o_hours   <= sat5(i_load_hours, HOUR_TOP);
      o_minutes <= sat6(i_load_minutes, MIN_TOP);
      o_seconds <= sat6(i_load_seconds, SEC_TOP);
    end else if (tick) begin
      o_hours   <= dec_hours;
      o_minutes <= dec_minutes;
      o_seconds <= dec_seconds;
    end
  end
endmodule
